// File: rtl/mix_columns_if.sv
// Block-level handshake between shiftrows and mix_columns.
// i_inv exists only when MIXCOL_INV_EN is defined.
interface mix_columns_if;
    logic         i_valid;
    logic [127:0] i_block;
    logic         i_bypass;
`ifdef MIXCOL_INV_EN
    logic         i_inv;
`endif
    logic         o_ready;
    logic         o_valid;
    logic [127:0] o_block;

    modport master (
`ifdef MIXCOL_INV_EN
        output i_inv,
`endif
        output i_valid, i_block, i_bypass,
        input  o_ready, o_valid, o_block
    );

    modport slave (
`ifdef MIXCOL_INV_EN
        input  i_inv,
`endif
        input  i_valid, i_block, i_bypass,
        output o_ready, o_valid, o_block
    );
endinterface

// File: rtl/mix_columns.sv
// Column-serial AES MixColumns: one 32-bit column per clock, 4-cycle latency, bypass for final round.
// Define MIXCOL_INV_EN to add the i_inv port and InvMixColumns datapath.
module mix_columns (
    input  logic         clk,
    input  logic         rst,
    mix_columns_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_nxt;
    logic         accept;
    logic [1:0]   col;
    logic [127:0] src;
    logic [127:0] result;
    logic         bypass_q;
    logic         valid_q;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
`ifdef MIXCOL_INV_EN
    logic         inv_q;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIXCOL_INV_EN
    // Multiples 9/b/d/e assembled from the x2, x4, x8 xtime chain.
    function automatic logic [7:0] mul09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.i_valid) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (col == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        col_in = '0;
        case (col)
            2'd0: col_in = src[127:96];
            2'd1: col_in = src[95:64];
            2'd2: col_in = src[63:32];
            2'd3: col_in = src[31:0];
            default: col_in = '0;
        endcase
    end

    always_comb begin
        col_out = mix_fwd(col_in);
`ifdef MIXCOL_INV_EN
        if (inv_q) col_out = mix_inv(col_in);
`endif
        if (bypass_q) col_out = col_in;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            src      <= '0;
            result   <= '0;
            bypass_q <= 1'b0;
            valid_q  <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            valid_q <= (state == RUN) && (col == 2'd3);
            if (accept) begin
                src      <= bus.i_block;
                bypass_q <= bus.i_bypass;
`ifdef MIXCOL_INV_EN
                inv_q    <= bus.i_inv;
`endif
                col      <= '0;
            end else if (state == RUN) begin
                case (col)
                    2'd0: result[127:96] <= col_out;
                    2'd1: result[95:64]  <= col_out;
                    2'd2: result[63:32]  <= col_out;
                    2'd3: result[31:0]   <= col_out;
                    default: ;
                endcase
                col <= col + 2'd1;
            end
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_block = result;
endmodule

// File: tb/tb_mix_columns.sv
// Directed scoreboard bench for mix_columns; expected blocks and due cycles are queued at accept.
module tb_mix_columns;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mix_columns_if bus ();
    mix_columns dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [127:0] blk;
        int           due;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input logic inv);
        logic [7:0]   m[4];
        logic [7:0]   a[4];
        logic [7:0]   s;
        logic [127:0] r;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = blk[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                s = '0;
                for (int k = 0; k < 4; k++) s = s ^ gmul(m[(k - row + 4) % 4], a[k]);
                r[127 - 32*c - 8*row -: 8] = s;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample #1 after the edge, then service the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            chk({e.tag, "_valid_timeout"}, 128'(bus.o_valid), 128'(1));
        end
        if (bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 128'(bus.o_valid), 128'(0));
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_block"}, bus.o_block, e.blk);
                chk({e.tag, "_latency"}, 128'(cyc), 128'(e.due));
            end
        end
    endtask

    task automatic send(input logic [127:0] blk, input logic bypass, input logic inv,
                        input logic [127:0] exp, input string tag);
        exp_t e;
        bus.i_valid  = 1'b1;
        bus.i_block  = blk;
        bus.i_bypass = bypass;
`ifdef MIXCOL_INV_EN
        bus.i_inv    = inv;
`else
        if (inv) $display("note: inverse request ignored in forward-only build");
`endif
        e.blk = exp;
        e.due = cyc + 5;
        e.tag = tag;
        sb.push_back(e);
        tick();
        bus.i_valid  = 1'b0;
    endtask

    // Called right after an accept: ready stays low for 4 samples, then the o_valid cycle.
    task automatic wait_done(input string tag);
        repeat (4) begin
            chk({tag, "_ready_low"}, 128'(bus.o_ready), 128'(0));
            tick();
        end
        chk({tag, "_ready_back"}, 128'(bus.o_ready), 128'(1));
    endtask

    logic [127:0] r, a_exp, fwd;

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_block  = '0;
        bus.i_bypass = 1'b0;
`ifdef MIXCOL_INV_EN
        bus.i_inv    = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_valid", 128'(bus.o_valid), 128'(0));
        chk("reset_ready", 128'(bus.o_ready), 128'(1));
        chk("reset_block", bus.o_block, '0);

        // FIPS-197 reference column set
        send(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, "fips");
        wait_done("fips");
        tick();

        send(FIPS_IN, 1'b1, 1'b0, FIPS_IN, "bypass");
        wait_done("bypass");
        tick();

        // Busy pulse two cycles after accept is dropped; next block lands in the o_valid cycle
        r = {$urandom, $urandom, $urandom, $urandom};
        a_exp = model(r, 1'b0);
        send(r, 1'b0, 1'b0, a_exp, "busy_a");
        tick();
        chk("busy_ready", 128'(bus.o_ready), 128'(0));
        bus.i_valid = 1'b1;
        bus.i_block = ~r;
        tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
        chk("busy_ready_back", 128'(bus.o_ready), 128'(1));
        r = {$urandom, $urandom, $urandom, $urandom};
        send(r, 1'b0, 1'b0, model(r, 1'b0), "b2b");
        chk("b2b_hold", bus.o_block, a_exp);
        repeat (3) begin
            chk("b2b_ready_low", 128'(bus.o_ready), 128'(0));
            tick();
        end
        tick();
        chk("b2b_ready_back", 128'(bus.o_ready), 128'(1));
        tick();

        for (int i = 0; i < 3; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, 1'b0, 1'b0, model(r, 1'b0), "rand_fwd");
            wait_done("rand_fwd");
            repeat (i) tick();
        end
        tick();

        // Reset on E2 aborts the block; i_valid on the reset edge is ignored
        send(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, "abort");
        tick();
        sb.delete();
        rst = 1'b1;
        bus.i_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        chk("abort_block", bus.o_block, '0);
        chk("abort_ready", 128'(bus.o_ready), 128'(1));
        chk("abort_valid", 128'(bus.o_valid), 128'(0));
        repeat (8) tick();
        chk("abort_ready_idle", 128'(bus.o_ready), 128'(1));

`ifdef MIXCOL_INV_EN
        send(FIPS_OUT, 1'b0, 1'b1, FIPS_IN, "fips_inv");
        wait_done("fips_inv");
        tick();
        r = {$urandom, $urandom, $urandom, $urandom};
        send(r, 1'b0, 1'b0, model(r, 1'b0), "round_fwd");
        wait_done("round_fwd");
        fwd = bus.o_block;
        tick();
        send(fwd, 1'b0, 1'b1, r, "round_inv");
        wait_done("round_inv");
        tick();
        send(r, 1'b1, 1'b1, r, "bypass_over_inv");
        wait_done("bypass_over_inv");
        tick();
`else
        fwd = '0;
`endif

        repeat (6) tick();
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mix_columns.md
# mix_columns

Column-serial AES MixColumns stage that sits directly downstream of `shiftrows` in the round datapath and consumes its `o_valid`/`o_block` output. It accepts one 128-bit state and transforms one 32-bit column per clock. It then presents the full result with a one-cycle valid pulse. A per-block bypass carries the final AES round, which has no MixColumns, through the same latency so that round timing stays uniform.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  input block present this cycle; single-cycle pulse from `shiftrows`.
- `i_block`  in  128  input state.
  - Byte b0 = [127:120] through b15 = [7:0].
  - Column c = bytes b(4c)..b(4c+3), i.e. `i_block[127-32c -: 32]`; row 0 is the MSB byte.
- `i_bypass`  in  1  sampled with the block; 1 = pass the state through unchanged (final round).
- `i_inv`  in  1  only present when `MIXCOL_INV_EN` is defined; 1 = InvMixColumns; sampled with the block.
- `o_ready`  out  1  block can accept a new input this cycle.
- `o_valid`  out  1  one-cycle pulse; `o_block` holds a new result.
- `o_block`  out  128  result state, same byte/column ordering as `i_block`.

## Operation
- **States: IDLE, RUN.** RUN carries a 2-bit column counter `col`.
- **Accept:** the block accepts an input on a rising edge where `i_valid && o_ready`.
  - Latch `i_block`, `i_bypass` and `i_inv`.
  - Set `col` = 0 and go to RUN.
  - Drive `o_ready` low.
- **Ignored input:** `i_valid` while `o_ready` = 0 is ignored. There is no stall and no error flag. The round controller must space inputs at least 5 cycles apart.
- **RUN, each edge:**
  - Compute column `col` from the latched state and write it into the result register at column `col`.
  - Increment `col`.
  - On the edge that writes column 3: go to IDLE, set `o_ready` = 1 and pulse `o_valid` = 1 for the following cycle.
- **Forward transform** per column (a0..a3 → s0..s3), all arithmetic in GF(2^8):
  - s0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - s1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - s2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - s3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- **xtime:** xtime(a) = {a[6:0],0} ^ (a[7] ? 8'h1b : 8'h00). Multiply by 3 is xtime(a) ^ a. All values are 8-bit with no carries.
- **Bypass:** the column is copied unchanged, with the same cycle count as a normal transform.
- **Result register:** `o_block` holds its value until the next block's column writes begin.
  - During RUN it is partially overwritten, column by column.
  - Consumers sample only on `o_valid`.

## Timing
- **Reset values:**
  - `o_valid` = 0, `o_block` = 128'h0, `o_ready` = 1.
  - State = IDLE, `col` = 0.
- **Latency:** the input is accepted on edge E0. Columns 0..3 are written on E1..E4. `o_valid` is high in the cycle after E4, i.e. 4 clocks after acceptance.
- **Ready:** `o_ready` is low from after E0 until after E4.
  - It returns high in the same cycle that `o_valid` pulses.
  - The next block can be accepted at E5 at the earliest, giving a throughput of 1 block per 5 cycles.
- **Simultaneous accept and output:** `i_valid` in the `o_valid` cycle is accepted. The `o_valid` pulse still occurs, and `o_block` stays stable through that cycle.
- **Reset mid-RUN:** `rst` on any edge aborts the block.
  - No `o_valid` is produced.
  - All outputs return to their reset values on that edge.
  - `i_valid` on a reset edge is ignored.
- **Registered outputs:** `o_valid` and `o_ready` are registered, with no combinational path from the inputs.

## Configuration
- **`MIXCOL_INV_EN` defined:**
  - The `i_inv` port exists.
  - When the latched `i_inv` = 1, columns use the InvMixColumns matrix (row 0 = 0e 0b 0d 09, rotated right per row). Multiples are built from chained xtime.
  - `i_bypass` = 1 overrides `i_inv`.
- **`MIXCOL_INV_EN` not defined:**
  - The `i_inv` port is absent and forward-only logic is built.
  - Timing is identical either way.

## Test plan
- **Reset:** assert `rst` for 2 edges. Expect `o_valid` = 0, `o_ready` = 1 and `o_block` = 0 in the first cycle after reset deasserts.
- **FIPS-197 columns:**
  - Input: `i_block` = 128'hdb135345_f20a225c_01010101_2d26314c, `i_bypass` = 0.
  - Expected: `o_block` = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8 with `o_valid` high exactly 4 clocks after acceptance and for one cycle.
  - `o_ready` is low for the intervening cycles.
- **Bypass:** send the same input with `i_bypass` = 1. Expect `o_block` = 128'hdb135345_f20a225c_01010101_2d26314c at the same latency.
- **Busy / back-to-back:**
  - Pulse `i_valid` 2 cycles after an accept. It is ignored, and exactly one `o_valid` results.
  - Present a second block in the `o_valid` cycle. It is accepted, and its result appears 4 clocks later.
- **Reset mid-operation:** assert `rst` on E2 of a block. Expect no `o_valid` ever for that block, `o_block` = 0 and `o_ready` = 1 afterwards.
- **`MIXCOL_INV_EN` build:**
  - `i_inv` = 1 on 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8 → 128'hdb135345_f20a225c_01010101_2d26314c.
  - Also apply a random vector forward and then inverse; expect the original vector back.
